// File: rtl/arb_pkg.sv
// Shared types for the command arbiter: FSM states, requester identity and command width.
package arb_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    GNT_TOUR,
    WAIT_TOUR,
    GNT_UART,
    WAIT_UART
  } arb_state_t;

  typedef enum logic {
    REQ_TOUR,
    REQ_UART
  } req_t;

  function automatic req_t state_owner(input arb_state_t s);
    return (s == GNT_TOUR || s == WAIT_TOUR) ? REQ_TOUR : REQ_UART;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for buffered UART commands; push and pop may coincide.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Owns cmd_proc's command port: grants tour or queued UART commands, routes handshakes back,
// and aborts a grant that never completes.
//   state     | meaning
//   IDLE      | no grant; pick tour first, else UART head when no tour is active
//   GNT_TOUR  | tour command presented, waiting for clr_cmd_rdy
//   WAIT_TOUR | tour command consumed, waiting for send_resp
//   GNT_UART  | FIFO head presented, waiting for clr_cmd_rdy (pops on clr)
//   WAIT_UART | UART command consumed, waiting for send_resp
module cmd_arbiter
  import arb_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [25:0] TIMEOUT_CYC = 26'd50_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   uart_cmd,
  input  logic                          uart_cmd_rdy,
  output logic                          uart_clr_cmd_rdy,
  output logic                          uart_send_resp,
  input  logic [15:0]                   tour_cmd,
  input  logic                          tour_cmd_rdy,
  input  logic                          tour_active,
  output logic                          tour_clr_cmd_rdy,
  output logic                          tour_send_resp,
  output logic [15:0]                   cmd,
  output logic                          cmd_rdy,
  input  logic                          clr_cmd_rdy,
  input  logic                          send_resp,
  output logic                          fifo_ovf,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CMD_W-1:0] fifo_head;
  logic [CMD_W-1:0] cmd_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             uart_take;
  logic             push;
  logic             pop;
  logic [25:0]      wd;
  logic             wd_expired;
  logic             wd_fire;

  // The cycle our clr is out, the wrapper still shows rdy high for the same command.
  assign uart_take  = uart_cmd_rdy & ~uart_clr_cmd_rdy;
  assign push       = uart_take & ~fifo_full;
  assign wd_expired = (wd == TIMEOUT_CYC - 26'd1);

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (uart_cmd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    cmd              = cmd_q;
    cmd_rdy          = 1'b0;
    pop              = 1'b0;
    tour_clr_cmd_rdy = 1'b0;
    tour_send_resp   = 1'b0;
    uart_send_resp   = 1'b0;
    wd_fire          = 1'b0;
    case (state)
      IDLE: begin
        if (tour_cmd_rdy)                    state_nxt = GNT_TOUR;
        else if (!tour_active && !fifo_empty) state_nxt = GNT_UART;
      end
      GNT_TOUR: begin
        cmd     = tour_cmd;
        cmd_rdy = tour_cmd_rdy;
        if (!tour_cmd_rdy) begin
          state_nxt = IDLE;
        end else if (clr_cmd_rdy) begin
          tour_clr_cmd_rdy = 1'b1;
          state_nxt        = WAIT_TOUR;
        end else if (wd_expired) begin
          wd_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GNT_UART: begin
        cmd     = fifo_head;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) begin
          pop       = 1'b1;
          state_nxt = WAIT_UART;
        end else if (wd_expired) begin
          wd_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_TOUR, WAIT_UART: begin
        if (send_resp) begin
          if (state_owner(state) == REQ_TOUR) tour_send_resp = 1'b1;
          else                                uart_send_resp = 1'b1;
          state_nxt = IDLE;
        end else if (wd_expired) begin
          wd_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One watchdog budget per grant: GNT->WAIT keeps counting, any return to IDLE clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd               <= '0;
      timeout_err      <= 1'b0;
      uart_clr_cmd_rdy <= 1'b0;
      fifo_ovf         <= 1'b0;
      cmd_q            <= '0;
    end else begin
      wd               <= (state == IDLE || state_nxt == IDLE) ? '0 : wd + 26'd1;
      timeout_err      <= wd_fire;
      uart_clr_cmd_rdy <= uart_take;
      if (uart_take && fifo_full) fifo_ovf <= 1'b1;
      if (state == GNT_TOUR || state == GNT_UART) cmd_q <= cmd;
    end
  end

endmodule
